// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a synchronous-read imem,
// and buffers up to two fetched words for decode behind valid/ready.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   output logic        imem_stall,
   input  logic [15:0] imem_instr,
   output logic        if_valid,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc
);

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   logic [15:0] pc;
   logic        inflight;
   logic [15:0] inflight_pc;
   logic [1:0]  count;
   entry_t      head;
   entry_t      tail;

   logic        pop;
   logic        push;
   logic        space;
   logic        issue;
   logic [2:0]  occ;
   logic [1:0]  count_nxt;
   entry_t      head_nxt;
   entry_t      tail_nxt;
   entry_t      new_e;

   assign pop   = if_valid & id_ready & ~redirect_valid;
   assign push  = inflight;
   assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign space = (occ < 3'd2);
   assign issue = ~rst & ~redirect_valid & space;

   assign imem_addr  = pc;
   assign imem_stall = ~issue;

   assign if_valid = (count != 2'd0);
   assign if_instr = head.instr;
   assign if_pc    = head.pc;

   // Head stays put when the last word leaves so outputs hold when empty.
   always_comb begin
      head_nxt  = head;
      tail_nxt  = tail;
      count_nxt = count;
      new_e     = '{instr: imem_instr, pc: inflight_pc};
      unique case ({push, pop})
         2'b11: begin
            if (count == 2'd2) begin
               head_nxt = tail;
               tail_nxt = new_e;
            end else begin
               head_nxt = new_e;
            end
         end
         2'b10: begin
            if (count == 2'd0) head_nxt = new_e;
            else               tail_nxt = new_e;
            count_nxt = count + 2'd1;
         end
         2'b01: begin
            if (count == 2'd2) head_nxt = tail;
            count_nxt = count - 2'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 16'h0000;
         count       <= 2'd0;
         head        <= '0;
         tail        <= '0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
         count    <= 2'd0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
            pc          <= pc + 16'd1;
         end
         head  <= head_nxt;
         tail  <= tail_nxt;
         count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard queues of expected PCs,
// a negedge monitor pops on each accepted word.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imem_addr;
   logic        imem_stall;
   logic [15:0] imem_instr;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [15:0] redirect_pc;

   logic [15:0] w_addr;
   logic        w_stall;
   logic [15:0] w_imem;
   logic        w_valid;
   logic [15:0] w_instr;
   logic [15:0] w_pc;

   int checks   = 0;
   int failures = 0;

   logic [15:0] q[$];
   logic [15:0] wq[$];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_stall     (imem_stall),
      .imem_instr     (imem_instr),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (w_addr),
      .imem_stall     (w_stall),
      .imem_instr     (w_imem),
      .if_valid       (w_valid),
      .if_instr       (w_instr),
      .if_pc          (w_pc),
      .id_ready       (1'b1),
      .redirect_valid (1'b0),
      .redirect_pc    (16'h0000)
   );

   // Synchronous-read memories: mem[a] = A000 + a
   always @(posedge clk) begin
      if (!imem_stall) imem_instr <= 16'hA000 + imem_addr;
      if (!w_stall)    w_imem     <= 16'hA000 + w_addr;
   end

   always @(negedge clk) begin
      logic [15:0] e;
      if (!rst) begin
         if (if_valid && id_ready && !redirect_valid) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL deliver: got unexpected pc=%h, required none", if_pc);
            end else begin
               e = q.pop_front();
               if (if_pc !== e || if_instr !== 16'hA000 + e) begin
                  failures++;
                  $display("FAIL deliver: got pc=%h instr=%h, required pc=%h instr=%h",
                           if_pc, if_instr, e, 16'hA000 + e);
               end
            end
         end
         if (w_valid) begin
            checks++;
            if (wq.size() == 0) begin
               failures++;
               $display("FAIL wrap_deliver: got unexpected pc=%h, required none", w_pc);
            end else begin
               e = wq.pop_front();
               if (w_pc !== e || w_instr !== 16'hA000 + e) begin
                  failures++;
                  $display("FAIL wrap_deliver: got pc=%h instr=%h, required pc=%h instr=%h",
                           w_pc, w_instr, e, 16'hA000 + e);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] start);
      for (int i = 0; i < 200; i++) q.push_back(start + 16'(i));
   endtask

   task automatic wload();
      for (int i = 0; i < 200; i++) wq.push_back(16'hFFFE + 16'(i));
   endtask

   initial begin
      rst            = 1'b1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;

      repeat (3) cyc();
      #1;
      chk("rst_valid", {15'd0, if_valid}, 16'd0);
      chk("rst_instr", if_instr, 16'h0000);
      chk("rst_pc", if_pc, 16'h0000);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_stall", {15'd0, imem_stall}, 16'd1);
      chk("rst_waddr", w_addr, 16'hFFFE);

      cyc();
      rst = 1'b0;
      load(16'h0000);
      wload();
      #1;
      chk("c0_stall", {15'd0, imem_stall}, 16'd0);
      chk("c0_addr", imem_addr, 16'h0000);
      cyc(); #1;
      chk("c1_valid", {15'd0, if_valid}, 16'd0);
      cyc(); #1;
      chk("c2_valid", {15'd0, if_valid}, 16'd1);
      chk("c2_pc", if_pc, 16'h0000);
      chk("c2_instr", if_instr, 16'hA000);
      repeat (6) begin
         cyc(); #1;
         chk("stream_valid", {15'd0, if_valid}, 16'd1);
      end

      cyc();
      id_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         if (i >= 1) begin
            chk("bp_stall", {15'd0, imem_stall}, 16'd1);
            chk("bp_valid", {15'd0, if_valid}, 16'd1);
         end
      end
      id_ready = 1'b1;
      #1;
      chk("bp_release_stall", {15'd0, imem_stall}, 16'd0);
      repeat (5) cyc();

      id_ready = 1'b0;
      repeat (3) cyc();
      id_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      q.delete();
      load(16'h0040);
      #1;
      chk("rd_stall", {15'd0, imem_stall}, 16'd1);
      cyc();
      redirect_valid = 1'b0;
      #1;
      chk("rd1_addr", imem_addr, 16'h0040);
      chk("rd1_stall", {15'd0, imem_stall}, 16'd0);
      chk("rd1_valid", {15'd0, if_valid}, 16'd0);
      cyc(); #1;
      chk("rd2_valid", {15'd0, if_valid}, 16'd0);
      cyc(); #1;
      chk("rd3_valid", {15'd0, if_valid}, 16'd1);
      chk("rd3_pc", if_pc, 16'h0040);
      repeat (4) cyc();

      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      q.delete();
      cyc();
      redirect_pc = 16'h0200;
      q.delete();
      load(16'h0200);
      cyc();
      redirect_valid = 1'b0;
      #1;
      chk("b2b_addr", imem_addr, 16'h0200);
      chk("b2b1_valid", {15'd0, if_valid}, 16'd0);
      cyc(); #1;
      chk("b2b2_valid", {15'd0, if_valid}, 16'd0);
      cyc(); #1;
      chk("b2b3_valid", {15'd0, if_valid}, 16'd1);
      chk("b2b3_pc", if_pc, 16'h0200);
      repeat (4) cyc();

      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0300;
      q.delete();
      wq.delete();
      cyc(); #1;
      chk("mrst_valid", {15'd0, if_valid}, 16'd0);
      chk("mrst_instr", if_instr, 16'h0000);
      chk("mrst_pc", if_pc, 16'h0000);
      chk("mrst_stall", {15'd0, imem_stall}, 16'd1);
      cyc();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      load(16'h0000);
      wload();
      #1;
      chk("mrst_c0_addr", imem_addr, 16'h0000);
      chk("wrap_c0_addr", w_addr, 16'hFFFE);
      cyc(); #1;
      chk("wrap_c1_addr", w_addr, 16'hFFFF);
      cyc(); #1;
      chk("mrst_c2_pc", if_pc, 16'h0000);
      chk("wrap_c2_addr", w_addr, 16'h0000);
      chk("wrap_c2_pc", w_pc, 16'hFFFE);
      cyc(); #1;
      chk("wrap_c3_pc", w_pc, 16'hFFFF);
      cyc(); #1;
      chk("wrap_c4_pc", w_pc, 16'h0000);
      chk("wrap_c4_instr", w_instr, 16'hA000);
      cyc(); #1;
      chk("wrap_c5_pc", w_pc, 16'h0001);
      repeat (4) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
